// File: rtl/unpack_telemetry_framed_if.sv
// Purpose: byte-stream input and packet/status output bundle for unpack_telemetry_framed.
// Latency: none (wiring only).
// Backpressure: none; the byte stream is qualified by valid_in only.
// Ports: k_in/data_in/valid_in (decoded link bytes), data_out/valid_out (assembled packet),
//        bad_short/bad_long/bad_kchar (error pulses), locked, pkt_count, err_count.
interface unpack_telemetry_framed_if #(
    parameter int g_data_width = 11,
    parameter int g_cnt_width  = 16
);
    logic                      k_in;
    logic [7:0]                data_in;
    logic                      valid_in;
    logic [g_data_width*8-1:0] data_out;
    logic                      valid_out;
    logic                      bad_short;
    logic                      bad_long;
    logic                      bad_kchar;
    logic                      locked;
    logic [g_cnt_width-1:0]    pkt_count;
    logic [g_cnt_width-1:0]    err_count;

    // Byte source side
    modport master (
        output k_in, data_in, valid_in,
        input  data_out, valid_out, bad_short, bad_long, bad_kchar,
        input  locked, pkt_count, err_count
    );

    // Unpacker side
    modport slave (
        input  k_in, data_in, valid_in,
        output data_out, valid_out, bad_short, bad_long, bad_kchar,
        output locked, pkt_count, err_count
    );
endinterface

// File: rtl/unpack_telemetry_framed.sv
// Purpose: assemble K-delimited decoded bytes into g_data_width-byte packets, flag malformed packets.
// Latency: valid_out / error pulses appear 2 clocks after the triggering valid_in byte.
// Backpressure: none; bytes are consumed whenever valid_in is high, idle cycles change no state.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries the byte input, the packet
//        output and the status outputs (locked, saturating pkt_count / err_count).
module unpack_telemetry_framed #(
    parameter int         g_data_width      = 11,
    parameter logic [7:0] g_k_char          = 8'hBC,
    parameter bit         g_require_trailer = 1'b0,
    parameter int         g_cnt_width       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    unpack_telemetry_framed_if.slave   bus
);
    localparam int CW = $clog2(g_data_width + 1);
    localparam logic [CW-1:0] N_FULL = CW'(g_data_width);
    localparam logic [CW-1:0] N_LAST = CW'(g_data_width - 1);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_RECV,
        ST_OVERRUN
    } state_t;

    state_t                    state;
    logic [CW-1:0]             count;
    logic                      long_seen;   // bad_long already raised for this overrun
    logic [g_data_width*8-1:0] asm_q;

    // Stage 1: per-byte events decided in the FSM
    logic rel_s1, short_s1, long_s1, kchar_s1;

    // Stage 2: registered outputs
    logic [g_data_width*8-1:0] data_q;
    logic                      valid_q, short_q, long_q, kchar_q, locked_q;
    logic [g_cnt_width-1:0]    pkt_q, err_q;

    logic is_delim, is_data, is_kother;

    assign is_delim  = bus.valid_in &  bus.k_in & (bus.data_in == g_k_char);
    assign is_kother = bus.valid_in &  bus.k_in & (bus.data_in != g_k_char);
    assign is_data   = bus.valid_in & ~bus.k_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_HUNT;
            count     <= '0;
            long_seen <= 1'b0;
            asm_q     <= '0;
            rel_s1    <= 1'b0;
            short_s1  <= 1'b0;
            long_s1   <= 1'b0;
            kchar_s1  <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            kchar_q   <= 1'b0;
            locked_q  <= 1'b0;
            pkt_q     <= '0;
            err_q     <= '0;
        end else begin
            rel_s1   <= 1'b0;
            short_s1 <= 1'b0;
            long_s1  <= 1'b0;
            kchar_s1 <= 1'b0;

            case (state)
                ST_HUNT: begin
                    if (is_delim) begin
                        state <= ST_RECV;
                        count <= '0;
                    end
                end

                ST_RECV: begin
                    if (is_data) begin
                        if (count == N_FULL) begin
                            // Only reachable with a trailer required: byte N+1 before the delimiter
                            long_s1   <= 1'b1;
                            long_seen <= 1'b1;
                            state     <= ST_OVERRUN;
                        end else begin
                            for (int i = 0; i < g_data_width; i++) begin
                                if (count == CW'(i)) begin
                                    asm_q[i*8 +: 8] <= bus.data_in;
                                end
                            end
                            if ((count == N_LAST) && !g_require_trailer) begin
                                rel_s1    <= 1'b1;
                                long_seen <= 1'b0;
                                count     <= '0;
                                state     <= ST_OVERRUN;
                            end else begin
                                count <= count + CW'(1);
                            end
                        end
                    end else if (is_delim) begin
                        // count==0 is an idle delimiter: no error, keep waiting
                        if (count == N_FULL) begin
                            rel_s1 <= 1'b1;
                        end else if (count != '0) begin
                            short_s1 <= 1'b1;
                        end
                        count <= '0;
                    end else if (is_kother) begin
                        kchar_s1 <= 1'b1;
                        state    <= ST_HUNT;
                    end
                end

                ST_OVERRUN: begin
                    if (is_data) begin
                        if (!long_seen) begin
                            long_s1   <= 1'b1;
                            long_seen <= 1'b1;
                        end
                    end else if (is_delim) begin
                        state <= ST_RECV;
                        count <= '0;
                    end else if (is_kother) begin
                        state <= ST_HUNT;
                    end
                end

                default: begin
                    state <= ST_HUNT;
                    count <= '0;
                end
            endcase

            // Stage 2. asm_q is read before any overwrite by the next byte (non-blocking),
            // so data_out always captures the complete packet.
            valid_q <= rel_s1;
            short_q <= short_s1;
            long_q  <= long_s1;
            kchar_q <= kchar_s1;

            if (rel_s1) begin
                data_q   <= asm_q;
                locked_q <= 1'b1;
                if (pkt_q != '1) begin
                    pkt_q <= pkt_q + g_cnt_width'(1);
                end
            end

            // At most one of the error events is set per byte
            if (short_s1 | long_s1 | kchar_s1) begin
                locked_q <= 1'b0;
                if (err_q != '1) begin
                    err_q <= err_q + g_cnt_width'(1);
                end
            end
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.bad_short = short_q;
    assign bus.bad_long  = long_q;
    assign bus.bad_kchar = kchar_q;
    assign bus.locked    = locked_q;
    assign bus.pkt_count = pkt_q;
    assign bus.err_count = err_q;

endmodule
